avalon_pio_v2: RTL and testbench
================================

// Module: avalon_pio_v2
// PURPOSE
//  Parametrised Avalon-MM PIO, successor to the fixed 8-bit output-only LED port.
//  Provides a WIDTH-bit output register with atomic set/clear, and a synchronised WIDTH-bit input port.
//  Input port has per-bit edge capture and a maskable level interrupt.
//  Sits on the Qsys system interconnect as a slave; drives LEDs/GPIO and samples switches/keys.
// PARAMETERS
//  WIDTH        8      port width, legal 1..32
//  RESET_VALUE  0      out_port value after reset (WIDTH bits)
//  SYNC_STAGES  2      input synchroniser flops, legal 2..4
//  EDGE_TYPE    0      0=rising, 1=falling, 2=any edge captured
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   3      word address
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  read_n      in   1      active-low read strobe
//  writedata   in   32     write data; bits above WIDTH ignored
//  readdata    out  32     read data, registered, valid 1 cycle after read; upper bits 0
//  in_port     in   WIDTH  asynchronous external inputs
//  out_port    out  WIDTH  output register
//  irq         out  1      level interrupt, registered
// BEHAVIOUR
//  Write = chipselect & ~write_n; read = chipselect & ~read_n; both sampled on posedge clk.
//  Register map (word address):
//   0 DATA    RW  out register; write loads writedata[WIDTH-1:0]
//   1 INPUT   RO  synchronised in_port
//   2 IRQMASK RW  per-bit interrupt enable
//   3 EDGECAP R/W1C  captured edges; write 1 clears bit
//   4 OUTSET  WO  out |= writedata; reads 0
//   5 OUTCLR  WO  out &= ~writedata; reads 0
//   6,7       reserved: read 0, writes ignored
//  Reset: out_port=RESET_VALUE, readdata=0, irq=0, IRQMASK=0, EDGECAP=0, sync flops=0.
//  out_port changes the cycle after the write (1-cycle write latency). Readdata is 1 cycle after read.
//  Readdata is held until the next read. Writes to read-only addresses have no effect.
//  Synchroniser: in_port passes through SYNC_STAGES flops. The edge detector compares the last sync stage with one extra delay flop.
//  Edge set and W1C clear of the same bit in the same cycle: set wins (bit stays 1).
//  EDGECAP read in the same cycle as a new edge returns the pre-edge value.
//  irq next = |(EDGECAP & IRQMASK) evaluated on registered values.
//  Reset asserted mid-operation clears all state asynchronously. The first edge after release is not detected until the pipeline refills (SYNC_STAGES+1 cycles).
//  Bits >= WIDTH of every register read as 0 and ignore writes.
// CONFIGURATION
//  Macro PIO_IRQ_EN:
//   defined     IRQMASK register implemented; irq driven as above.
//   not defined IRQMASK absent (addr 2 reads 0, writes ignored); irq tied 0. EDGECAP is still implemented.
// STRUCTURE
//  Package pio_pkg: address constants (PIO_ADDR_DATA..PIO_ADDR_OUTCLR) and edge-type constants (EDGE_RISE/FALL/ANY).
//  Sub-module pio_sync_edge: synchroniser plus edge detector.
//   Params WIDTH, SYNC_STAGES, EDGE_TYPE.
//   Outputs: sync_q[WIDTH] and edge_pulse[WIDTH], a one-cycle pulse per detected edge.
//  Top module holds the registers, address decode, read mux and irq.
// TESTING
//  Reset with RESET_VALUE=8'hA5 -> out_port=A5, readdata=0, irq=0. Read addr0 -> A5 one cycle later.
//  Write DATA=8'h0F; OUTSET 8'hF0 -> out_port=FF; OUTCLR 8'h81 -> 7E. Reads of addr4/5 -> 0.
//  EDGE_TYPE=0: toggle in_port[3] 0->1 -> EDGECAP=08 after SYNC_STAGES+1 cycles. A 1->0 toggle adds nothing.
//  Write EDGECAP=08 in the same cycle a new edge_pulse[3] fires -> EDGECAP stays 08.
//  PIO_IRQ_EN on: IRQMASK=08, edge on bit 3 -> irq=1. W1C 08 -> irq=0 next cycle. Mask 00 -> irq stays 0.
//  Assert reset_n low mid-write of DATA=3C -> out_port returns to RESET_VALUE immediately. No write takes effect.

Source files
------------

// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared constants for the Avalon-MM PIO
//
// Purpose: word-address map and edge-type encodings used by avalon_pio_v2
//          and pio_sync_edge.
// Ports:   none (package).
package pio_pkg;

   // Register word addresses; 6 and 7 are reserved
   localparam logic [2:0] PIO_ADDR_DATA    = 3'd0;
   localparam logic [2:0] PIO_ADDR_INPUT   = 3'd1;
   localparam logic [2:0] PIO_ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] PIO_ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] PIO_ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] PIO_ADDR_OUTCLR  = 3'd5;

   // Edge detector selection
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// rtl/pio_sync_edge.sv - input synchroniser with per-bit edge detector
//
// Purpose: passes asynchronous inputs through SYNC_STAGES flops, then compares
//          the last stage with one extra delay flop to produce edge pulses.
// Ports:
//   clk        in  1      system clock
//   reset_n    in  1      asynchronous active-low reset
//   async_i    in  WIDTH  raw external inputs
//   sync_q     out WIDTH  synchronised inputs (last synchroniser stage)
//   edge_pulse out WIDTH  one-cycle pulse per detected edge
module pio_sync_edge
   import pio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_q,
   output logic [WIDTH-1:0] edge_pulse
);

   logic [WIDTH-1:0] stage_q [SYNC_STAGES];
   logic [WIDTH-1:0] dly_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= '0;
         end
         dly_q <= '0;
      end else begin
         stage_q[0] <= async_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
         dly_q <= stage_q[SYNC_STAGES-1];
      end
   end

   assign sync_q = stage_q[SYNC_STAGES-1];

   // Pulse is combinational from registered values, so it lasts exactly one cycle
   generate
      if (EDGE_TYPE == EDGE_RISE) begin : g_rise
         assign edge_pulse = sync_q & ~dly_q;
      end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
         assign edge_pulse = ~sync_q & dly_q;
      end else begin : g_any
         assign edge_pulse = sync_q ^ dly_q;
      end
   endgenerate

endmodule

// File: rtl/avalon_pio_v2.sv
// rtl/avalon_pio_v2.sv - parametrised Avalon-MM PIO slave
//
// Purpose: WIDTH-bit output register with atomic set/clear, synchronised input
//          port with edge capture (W1C) and optional maskable level interrupt.
//          Optional feature macro: PIO_IRQ_EN (IRQMASK register and irq output).
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   address[2:0]         word address
//   chipselect           slave select
//   write_n, read_n      active-low strobes
//   writedata[31:0]      write data (bits >= WIDTH ignored)
//   readdata[31:0]       registered read data, held until next read
//   in_port[WIDTH-1:0]   asynchronous inputs
//   out_port[WIDTH-1:0]  output register
//   irq                  registered level interrupt
module avalon_pio_v2
   import pio_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               SYNC_STAGES = 2,
   parameter int               EDGE_TYPE   = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic             read_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] wdata;
   logic [31:0]      unused_wdata;

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [31:0]      readdata_q, rd_word;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] edge_pulse;

   assign wr_en        = chipselect & ~write_n;
   assign rd_en        = chipselect & ~read_n;
   assign wdata        = writedata[WIDTH-1:0];
   assign unused_wdata = writedata;

   pio_sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync_edge (
      .clk        (clk),
      .reset_n    (reset_n),
      .async_i    (in_port),
      .sync_q     (sync_q),
      .edge_pulse (edge_pulse)
   );

`ifdef PIO_IRQ_EN
   logic [WIDTH-1:0] mask_q, mask_d;
   logic             irq_q;

   always_comb begin
      mask_d = mask_q;
      if (wr_en && address == PIO_ADDR_IRQMASK) begin
         mask_d = wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         mask_q <= mask_d;
         irq_q  <= |(edgecap_q & mask_q);
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      out_d = out_q;
      if (wr_en) begin
         case (address)
            PIO_ADDR_DATA:   out_d = wdata;
            PIO_ADDR_OUTSET: out_d = out_q | wdata;
            PIO_ADDR_OUTCLR: out_d = out_q & ~wdata;
            default:         out_d = out_q;
         endcase
      end
   end

   // Clear first, then OR in new edges: a same-cycle edge keeps its bit set
   always_comb begin
      edgecap_d = edgecap_q;
      if (wr_en && address == PIO_ADDR_EDGECAP) begin
         edgecap_d = edgecap_q & ~wdata;
      end
      edgecap_d = edgecap_d | edge_pulse;
   end

   // Read mux uses registered values, so EDGECAP reads return the pre-edge value
   always_comb begin
      rd_word = '0;
      case (address)
         PIO_ADDR_DATA:    rd_word[WIDTH-1:0] = out_q;
         PIO_ADDR_INPUT:   rd_word[WIDTH-1:0] = sync_q;
`ifdef PIO_IRQ_EN
         PIO_ADDR_IRQMASK: rd_word[WIDTH-1:0] = mask_q;
`endif
         PIO_ADDR_EDGECAP: rd_word[WIDTH-1:0] = edgecap_q;
         default:          rd_word = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q      <= RESET_VALUE;
         edgecap_q  <= '0;
         readdata_q <= '0;
      end else begin
         out_q     <= out_d;
         edgecap_q <= edgecap_d;
         if (rd_en) begin
            readdata_q <= rd_word;
         end
      end
   end

   assign out_port = out_q;
   assign readdata = readdata_q;

endmodule

// File: tb/tb_avalon_pio_v2.sv
// tb/tb_avalon_pio_v2.sv - self-checking bench for avalon_pio_v2
module tb_avalon_pio_v2;

   localparam int         W  = 8;
   localparam logic [7:0] RV = 8'hA5;
   localparam int         S  = 2;
   localparam int         E  = 0;
`ifdef PIO_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [2:0]   address = '0;
   logic         chipselect = 1'b0;
   logic         write_n = 1'b1;
   logic         read_n = 1'b1;
   logic [31:0]  writedata = '0;
   logic [31:0]  readdata;
   logic [W-1:0] in_port = '0;
   logic [W-1:0] out_port;
   logic         irq;

   avalon_pio_v2 #(
      .WIDTH(W), .RESET_VALUE(RV), .SYNC_STAGES(S), .EDGE_TYPE(E)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .read_n(read_n), .writedata(writedata),
      .readdata(readdata), .in_port(in_port), .out_port(out_port), .irq(irq)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference model: register contents plus a history of sampled in_port values
   logic [7:0]  m_out, m_mask, m_ecap, cur_in;
   logic        m_irq;
   logic [31:0] m_rd;
   logic [7:0]  samp[$];

   task automatic model_reset();
      m_out = RV; m_mask = '0; m_ecap = '0; m_irq = 1'b0; m_rd = '0;
      samp = {};
      repeat (S + 2) samp.push_front(8'h00);
   endtask

   // One bus cycle: drive, clock, update model, then compare outputs
   task automatic step(input logic [2:0] a, input bit cs, input bit wn, input bit rn,
                       input logic [31:0] wd, input logic [7:0] inp);
      bit         wr, rd;
      logic [7:0] nw, od, pulse, syn, wd8;
      address = a; chipselect = cs; write_n = wn; read_n = rn;
      writedata = wd; in_port = inp; cur_in = inp;
      @(posedge clk);
      wr = cs && !wn; rd = cs && !rn; wd8 = wd[7:0];
      samp.push_front(inp);
      // A sample is seen by the edge detector S edges after it was taken
      nw = samp[S]; od = samp[S+1]; syn = samp[S];
      void'(samp.pop_back());
      case (E)
         0:       pulse = nw & ~od;
         1:       pulse = ~nw & od;
         default: pulse = nw ^ od;
      endcase
      if (rd) begin
         case (a)
            3'd0:    m_rd = {24'h0, m_out};
            3'd1:    m_rd = {24'h0, syn};
            3'd2:    m_rd = IRQ_EN ? {24'h0, m_mask} : 32'h0;
            3'd3:    m_rd = {24'h0, m_ecap};
            default: m_rd = 32'h0;
         endcase
      end
      m_irq = IRQ_EN ? |(m_ecap & m_mask) : 1'b0;
      m_ecap = ((wr && a == 3'd3) ? (m_ecap & ~wd8) : m_ecap) | pulse;
      if (wr && a == 3'd2 && IRQ_EN) m_mask = wd8;
      if (wr && a == 3'd0) m_out = wd8;
      if (wr && a == 3'd4) m_out = m_out | wd8;
      if (wr && a == 3'd5) m_out = m_out & ~wd8;
      #1;
      chk("model_out", {24'h0, out_port}, {24'h0, m_out});
      chk("model_irq", {31'h0, irq}, {31'h0, m_irq});
      chk("model_rd", readdata, m_rd);
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      step(a, 1, 0, 1, d, cur_in);
   endtask
   task automatic rd_reg(input logic [2:0] a);
      step(a, 1, 1, 0, 32'h0, cur_in);
   endtask
   task automatic idle(input logic [7:0] inp);
      step(3'd0, 0, 1, 1, 32'h0, inp);
   endtask

   initial begin
      cur_in = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", {24'h0, out_port}, 32'hA5);
      chk("rst_rd", readdata, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      reset_n = 1'b1;

      rd_reg(3'd0);
      chk("rd_data_rst", readdata, 32'hA5);

      wr_reg(3'd0, 32'hFFFF_FF0F);
      chk("wr_data", {24'h0, out_port}, 32'h0F);
      wr_reg(3'd4, 32'h0000_00F0);
      chk("outset", {24'h0, out_port}, 32'hFF);
      wr_reg(3'd5, 32'h0000_0081);
      chk("outclr", {24'h0, out_port}, 32'h7E);
      rd_reg(3'd4);
      chk("rd_outset", readdata, 32'h0);
      rd_reg(3'd0);
      chk("rd_data", readdata, 32'h7E);
      rd_reg(3'd5);
      chk("rd_outclr", readdata, 32'h0);
      wr_reg(3'd1, 32'h55);
      wr_reg(3'd6, 32'h55);
      chk("ro_write", {24'h0, out_port}, 32'h7E);

      // Rising edge on bit 3: captured S edges after the first sample
      idle(8'h08);
      repeat (S - 1) idle(8'h08);
      rd_reg(3'd3);
      chk("ecap_pre_edge", readdata, 32'h0);
      rd_reg(3'd3);
      chk("ecap_rise", readdata, 32'h08);
      repeat (S + 3) idle(8'h00);
      rd_reg(3'd3);
      chk("ecap_fall_none", readdata, 32'h08);

      // W1C in the same cycle the new edge lands: set wins
      idle(8'h08);
      repeat (S - 1) idle(8'h08);
      wr_reg(3'd3, 32'h08);
      rd_reg(3'd3);
      chk("ecap_set_wins", readdata, 32'h08);
      wr_reg(3'd3, 32'h08);
      rd_reg(3'd3);
      chk("ecap_w1c", readdata, 32'h0);

      // Interrupt path
      wr_reg(3'd2, 32'h08);
      rd_reg(3'd2);
      chk("rd_mask", readdata, IRQ_EN ? 32'h08 : 32'h0);
      repeat (S + 2) idle(8'h00);
      repeat (S + 2) idle(8'h08);
      chk("irq_set", {31'h0, irq}, {31'h0, IRQ_EN});
      wr_reg(3'd3, 32'h08);
      idle(8'h08);
      chk("irq_clr", {31'h0, irq}, 32'h0);
      wr_reg(3'd2, 32'h00);
      repeat (S + 2) idle(8'h00);
      repeat (S + 3) idle(8'h08);
      chk("irq_masked", {31'h0, irq}, 32'h0);
      rd_reg(3'd3);
      chk("ecap_masked", readdata, 32'h08);

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [7:0] nin;
         nin = ($urandom_range(0, 3) == 0) ? 8'($urandom) : cur_in;
         step(3'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
              1'($urandom), $urandom, nin);
      end

      // Reset in the middle of a DATA write
      address = 3'd0; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1;
      writedata = 32'h3C;
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_out", {24'h0, out_port}, 32'hA5);
      chk("mid_rst_rd", readdata, 32'h0);
      chk("mid_rst_irq", {31'h0, irq}, 32'h0);
      model_reset();
      cur_in = in_port;
      @(posedge clk);
      #1;
      chk("rst_hold_out", {24'h0, out_port}, 32'hA5);
      chipselect = 1'b0; write_n = 1'b1;
      reset_n = 1'b1;
      idle(cur_in);
      chk("post_rst_out", {24'h0, out_port}, 32'hA5);
      rd_reg(3'd3);
      chk("post_rst_ecap", readdata, 32'h0);
      for (int i = 0; i < 100; i++) begin
         step(3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
              8'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
